control_muestreo: RTL and testbench

CONTROL_MUESTREO -- requirements
Module: control_muestreo

---
 rtl/control_muestreo_if.sv | 10 +
 rtl/control_muestreo.sv | 120 ++++++++++++
 tb/tb_control_muestreo.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_muestreo_if.sv
// rtl/control_muestreo_if.sv - conversion handshake between the sample controller and the serial capture block
interface control_muestreo_if;
  logic        EN;
  logic        Listo;
  logic [3:0]  Zeros;
  logic [11:0] Dato;

  modport master (output EN, input Listo, input Zeros, input Dato);
  modport slave  (input EN, output Listo, output Zeros, output Dato);
endinterface

// File: rtl/control_muestreo.sv
// rtl/control_muestreo.sv - periodic conversion controller for a serial capture block
// Optional AVG4_EN: deliver the truncated mean of every four accepted samples.
module control_muestreo #(
  parameter int unsigned PERIOD_MIN = 20,
  parameter int unsigned TIMEOUT    = 40
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        periodo,
  input  logic               clr_err,
  control_muestreo_if.master cap,
  output logic [11:0]        muestra,
  output logic               muestra_valida,
  output logic               busy,
  output logic               err_zeros,
  output logic               err_timeout,
  output logic [15:0]        n_muestras
);
  typedef enum logic [1:0] {IDLE, ARM, WAIT, HOLD} state_t;

  localparam logic [15:0] PMIN     = 16'(PERIOD_MIN);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [15:0] pcnt, tcnt, per_load;
  logic        accept, reject, tmo, deliver;
  logic [11:0] value;

  assign per_load = ((periodo < PMIN) ? PMIN : periodo) - 16'd1;
  assign cap.EN   = (state == ARM);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    reject     = 1'b0;
    tmo        = 1'b0;
    case (state)
      IDLE: if (start) state_next = ARM;
      ARM:  state_next = WAIT;
      WAIT: begin
        if (cap.Listo) begin
          accept     = (cap.Zeros == 4'h0);
          reject     = (cap.Zeros != 4'h0);
          state_next = HOLD;
        end else if (tcnt == TMO_LAST) begin
          tmo        = 1'b1;
          state_next = HOLD;
        end
      end
      HOLD: if (pcnt == 16'd0) state_next = start ? ARM : IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef AVG4_EN
  logic [13:0] acc, acc_sum;
  logic [1:0]  acc_n;

  assign acc_sum = acc + {2'b00, cap.Dato};
  assign deliver = accept && (acc_n == 2'd3);
  assign value   = acc_sum[13:2];

  // Partial sums never survive a return to IDLE, so a restart begins a fresh group of four.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc   <= '0;
      acc_n <= '0;
    end else if (state == HOLD && state_next == IDLE) begin
      acc   <= '0;
      acc_n <= '0;
    end else if (accept) begin
      if (acc_n == 2'd3) begin
        acc   <= '0;
        acc_n <= '0;
      end else begin
        acc   <= acc_sum;
        acc_n <= acc_n + 2'd1;
      end
    end
  end
`else
  assign deliver = accept;
  assign value   = cap.Dato;
`endif

  // Counters load on the edge entering ARM, so EN-to-EN spacing equals the clamped period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt           <= '0;
      tcnt           <= '0;
      muestra        <= '0;
      muestra_valida <= 1'b0;
      n_muestras     <= '0;
      err_zeros      <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      if (state_next == ARM) begin
        pcnt <= per_load;
        tcnt <= '0;
      end else begin
        if (state != IDLE && pcnt != 16'd0) pcnt <= pcnt - 16'd1;
        if (state == ARM || state == WAIT)  tcnt <= tcnt + 16'd1;
      end
      muestra_valida <= deliver;
      if (deliver) begin
        muestra    <= value;
        n_muestras <= n_muestras + 16'd1;
      end
      err_zeros   <= reject | (err_zeros & ~clr_err);
      err_timeout <= tmo | (err_timeout & ~clr_err);
    end
  end
endmodule

// File: tb/tb_control_muestreo.sv
// tb/tb_control_muestreo.sv - bench for control_muestreo: vector table, corner sequences, randomized runs
module tb_control_muestreo;
  localparam int TIMEOUT = 40;
  localparam int PMIN    = 20;

  logic        clk = 1'b0;
  logic        rst, start, clr_err;
  logic [15:0] periodo;
  logic [11:0] muestra;
  logic        muestra_valida, busy, err_zeros, err_timeout;
  logic [15:0] n_muestras;

  control_muestreo_if cap();

  control_muestreo #(.PERIOD_MIN(PMIN), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .periodo(periodo), .clr_err(clr_err),
    .cap(cap), .muestra(muestra), .muestra_valida(muestra_valida), .busy(busy),
    .err_zeros(err_zeros), .err_timeout(err_timeout), .n_muestras(n_muestras)
  );

  initial forever #5 clk = ~clk;

  typedef struct { int cyc; logic [11:0] val; } exp_t;
  typedef struct {
    logic [15:0] p; int lat; int zm;
    int sp; int nval; bit ez; bit et;
  } vec_t;

  exp_t        exp_q[$];
  int          en_q[$];
  logic [11:0] acc_q[$];
  logic [11:0] dato_q[$];
  int cyc = 0, countdown = 0, lat = 0, zmode = 0, n_exp = 0, et_rise = -1;
  int n_cmp = 0, n_bad = 0;
  bit model_on, armed, exp_ez, exp_et, clr_on_listo, prev_et;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic model_accept(input logic [11:0] d, input int c);
    exp_t e;
    int   sum;
`ifdef AVG4_EN
    acc_q.push_back(d);
    if (acc_q.size() == 4) begin
      sum = 0;
      foreach (acc_q[i]) sum += int'(acc_q[i]);
      e.cyc = c;
      e.val = 12'(sum / 4);
      exp_q.push_back(e);
      n_exp++;
      acc_q.delete();
    end
`else
    sum   = 0;
    e.cyc = c + sum;
    e.val = d;
    exp_q.push_back(e);
    n_exp++;
`endif
  endtask

  task automatic fire();
    cap.Listo = 1'b1;
    cap.Zeros = (zmode == 1 || (zmode == 2 && $urandom_range(0, 2) == 0)) ? 4'($urandom_range(1, 15)) : 4'h0;
    cap.Dato  = (dato_q.size() > 0) ? dato_q.pop_front() : 12'($urandom);
    if (clr_on_listo) clr_err = 1'b1;
    if (armed && lat < TIMEOUT) begin
      if (cap.Zeros == 4'h0) model_accept(cap.Dato, cyc + 1);
      else                   exp_ez = 1'b1;
    end
    armed = 1'b0;
  endtask

  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    cap.Listo = 1'b0;
    clr_err   = 1'b0;
    if (muestra_valida) begin
      if (exp_q.size() == 0) chk("unexpected_valid", muestra_valida, 0);
      else begin
        e = exp_q.pop_front();
        chk("valid_cycle", cyc, e.cyc);
        chk("muestra", muestra, e.val);
      end
    end
    if (err_timeout && !prev_et && et_rise < 0) et_rise = cyc;
    prev_et = err_timeout;
    if (!busy) acc_q.delete();
    if (cap.EN) begin
      en_q.push_back(cyc);
      if (model_on) begin
        countdown = lat;
        armed     = 1'b1;
        if (lat >= TIMEOUT) exp_et = 1'b1;
      end
    end else if (countdown > 0) begin
      countdown--;
      if (countdown == 0) fire();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; clr_err = 1'b0; periodo = '0;
    cap.Listo = 1'b0; cap.Zeros = '0; cap.Dato = '0;
    model_on = 0; armed = 0; countdown = 0; clr_on_listo = 0;
    exp_q.delete(); en_q.delete(); acc_q.delete(); dato_q.delete();
    n_exp = 0; exp_ez = 0; exp_et = 0; et_rise = -1; prev_et = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run(input logic [15:0] p, input int l, input int zm, input int nen);
    int c0;
    en_q.delete();
    periodo = p; lat = l; zmode = zm; model_on = 1; start = 1'b1;
    c0 = cyc;
    for (int i = 0; i < nen * 80 + 20 && en_q.size() < nen; i++) step();
    chk("en_count", en_q.size(), nen);
    if (en_q.size() > 0) chk("start_to_en", en_q[0] - c0, 1);
    start = 1'b0;
    for (int i = 0; i < 200 && busy; i++) step();
    chk("idle_after_stop", busy, 0);
    model_on = 0;
  endtask

  task automatic wait_en();
    for (int i = 0; i < 100 && en_q.size() == 0; i++) step();
    chk("en_seen", en_q.size(), 1);
  endtask

  initial begin
    vecs[0] = '{16'd50,  18,   0, 50,  2, 1'b0, 1'b0};
    vecs[1] = '{16'd5,   18,   0, 20,  2, 1'b0, 1'b0};
    vecs[2] = '{16'd0,   10,   0, 20,  2, 1'b0, 1'b0};
    vecs[3] = '{16'd20,  38,   0, 40,  2, 1'b0, 1'b0};
    vecs[4] = '{16'd25,  39,   0, 41,  2, 1'b0, 1'b0};
    vecs[5] = '{16'd25,  40,   0, 41,  0, 1'b0, 1'b1};
    vecs[6] = '{16'd50,  1000, 0, 50,  0, 1'b0, 1'b1};
    vecs[7] = '{16'd30,  12,   1, 30,  0, 1'b1, 1'b0};
    vecs[8] = '{16'd100, 5,    0, 100, 2, 1'b0, 1'b0};

    // Outputs are forced low while reset is held, even with start high.
    rst = 1'b1; start = 1'b1; clr_err = 1'b0; periodo = 16'd50;
    cap.Listo = 1'b1; cap.Zeros = '0; cap.Dato = 12'hFFF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_EN", cap.EN, 0);
    chk("rst_busy", busy, 0);
    chk("rst_muestra", muestra, 0);
    chk("rst_valid", muestra_valida, 0);
    chk("rst_n_muestras", n_muestras, 0);
    chk("rst_errs", {err_zeros, err_timeout}, 0);

    foreach (vecs[k]) begin
      do_reset();
      run(vecs[k].p, vecs[k].lat, vecs[k].zm, 2);
      if (en_q.size() >= 2) chk("vec_spacing", en_q[1] - en_q[0], vecs[k].sp);
      chk("vec_err_zeros", err_zeros, vecs[k].ez);
      chk("vec_err_timeout", err_timeout, vecs[k].et);
      if (vecs[k].et && en_q.size() > 0) chk("vec_timeout_offset", et_rise - en_q[0], TIMEOUT);
`ifndef AVG4_EN
      chk("vec_n_muestras", n_muestras, vecs[k].nval);
`endif
      chk("vec_pending", exp_q.size(), 0);
    end

    do_reset();
    repeat (3) dato_q.push_back(12'hABC);
    run(16'd50, 18, 0, 3);
    if (en_q.size() >= 3) begin
      chk("p50_spacing1", en_q[1] - en_q[0], 50);
      chk("p50_spacing2", en_q[2] - en_q[1], 50);
    end
`ifndef AVG4_EN
    chk("p50_n_muestras", n_muestras, 3);
    chk("p50_muestra", muestra, 12'hABC);
`endif

    do_reset();
    run(16'd30, 12, 1, 1);
    chk("zeros_err", err_zeros, 1);
    chk("zeros_no_sample", n_muestras, 0);
    clr_err = 1'b1;
    step();
    chk("clr_err_clears", err_zeros, 0);
    clr_on_listo = 1;
    run(16'd30, 12, 1, 1);
    clr_on_listo = 0;
    chk("clr_set_wins", err_zeros, 1);

    // start dropped while a conversion is in flight: the sample still arrives, then idle.
    do_reset();
    periodo = 16'd50; lat = 20; zmode = 0; model_on = 1; start = 1'b1;
    wait_en();
    repeat (5) step();
    start = 1'b0;
    for (int i = 0; i < 200 && busy; i++) step();
    chk("drop_busy", busy, 0);
    chk("drop_n_muestras", n_muestras, n_exp);
    chk("drop_pending", exp_q.size(), 0);

    // Async reset mid-WAIT, then a late Listo lands in IDLE and must be ignored.
    en_q.delete();
    start = 1'b1;
    wait_en();
    repeat (8) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_EN", cap.EN, 0);
    chk("arst_busy", busy, 0);
    chk("arst_muestra", muestra, 0);
    chk("arst_n_muestras", n_muestras, 0);
    chk("arst_valid_errs", {muestra_valida, err_zeros, err_timeout}, 0);
    armed = 0; start = 1'b0; n_exp = 0;
    exp_q.delete(); acc_q.delete();
    step();
    rst = 1'b0;
    repeat (20) step();
    chk("late_listo_busy", busy, 0);
    chk("late_listo_n", n_muestras, 0);

    // Listo pulse while holding out the period is ignored.
    do_reset();
    periodo = 16'd50; lat = 5; zmode = 0; model_on = 1; start = 1'b1;
    wait_en();
    repeat (15) step();
    cap.Listo = 1'b1; cap.Zeros = 4'h0; cap.Dato = 12'h555;
    step();
    start = 1'b0;
    for (int i = 0; i < 200 && busy; i++) step();
    chk("hold_listo_n", n_muestras, n_exp);
    chk("hold_listo_pending", exp_q.size(), 0);

`ifdef AVG4_EN
    do_reset();
    dato_q.push_back(12'h100); dato_q.push_back(12'h200);
    dato_q.push_back(12'h300); dato_q.push_back(12'h401);
    run(16'd20, 10, 0, 4);
    chk("avg_n_muestras", n_muestras, 1);
    chk("avg_muestra", muestra, 12'h280);
`endif

    for (int t = 0; t < 12; t++) begin
      int p, l, nen, pc, sp;
      p   = $urandom_range(0, 60);
      l   = $urandom_range(1, 50);
      nen = $urandom_range(2, 5);
      do_reset();
      run(16'(p), l, $urandom_range(0, 2), nen);
      pc = (p < PMIN) ? PMIN : p;
      // Next ARM is the later of the period expiry and the cycle after entering HOLD.
      sp = (l < TIMEOUT) ? ((pc > l + 2) ? pc : l + 2) : ((pc > TIMEOUT + 1) ? pc : TIMEOUT + 1);
      for (int i = 1; i < en_q.size(); i++) chk("rnd_spacing", en_q[i] - en_q[i-1], sp);
      chk("rnd_n_muestras", n_muestras, n_exp);
      chk("rnd_pending", exp_q.size(), 0);
      chk("rnd_err_zeros", err_zeros, exp_ez);
      chk("rnd_err_timeout", err_timeout, exp_et);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
